// File: rtl/dpcm_pkg.sv
// rtl/dpcm_pkg.sv - shared encoding types and difference encoder for the DPCM path
package dpcm_pkg;

  typedef enum logic {
    DPCM_TWOS    = 1'b0,
    DPCM_SIGNMAG = 1'b1
  } dpcm_enc_e;

  localparam int DPCM_MAX_W = 32;

  // Result is valid in bits [width:0]; the caller truncates to its own WIDTH+1.
  function automatic logic [DPCM_MAX_W:0] encode_diff(
    input logic [DPCM_MAX_W-1:0] sample,
    input logic [DPCM_MAX_W-1:0] pred,
    input dpcm_enc_e             mode,
    input int                    width
  );
    logic [DPCM_MAX_W:0] diff;
    logic [DPCM_MAX_W:0] mag;
    logic                neg;
    diff = {1'b0, sample} - {1'b0, pred};
    neg  = (pred > sample);
    mag  = neg ? ({1'b0, pred} - {1'b0, sample}) : diff;
    if (mode == DPCM_TWOS) begin
      return diff;
    end
    return mag | ((DPCM_MAX_W+1)'(neg) << width);
  endfunction

endpackage

// File: rtl/dpcm_pred_bank.sv
// rtl/dpcm_pred_bank.sv - per-channel predictor array, combinational read, synchronous write
module dpcm_pred_bank
  import dpcm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH_W-1:0]  i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  input  logic             i_wr_en,
  input  logic [CH_W-1:0]  i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data
);

  logic [WIDTH-1:0] r_pred [CHANNELS];
  logic             w_rd_ok;
  logic             w_wr_ok;

  assign w_rd_ok = (32'(i_rd_addr) < CHANNELS);
  assign w_wr_ok = (32'(i_wr_addr) < CHANNELS);

  always_comb begin
    o_rd_data = '0;
    if (w_rd_ok) begin
      o_rd_data = r_pred[i_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_pred[i] <= '0;
      end
    end else if (i_wr_en && w_wr_ok) begin
      r_pred[i_wr_addr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/dpcm_diff_mc.sv
// rtl/dpcm_diff_mc.sv - multi-channel DPCM difference encoder; optional DPCM_RESYNC_EN adds Resync/ResyncOut
module dpcm_diff_mc
  import dpcm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter bit SIGNED_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid,
  output logic             Ready,
  input  logic [WIDTH-1:0] DataIn,
  input  logic [CH_W-1:0]  ChanIn,
`ifdef DPCM_RESYNC_EN
  input  logic             Resync,
  output logic             ResyncOut,
`endif
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH:0]   DataOut,
  output logic [CH_W-1:0]  ChanOut
);

  localparam dpcm_enc_e ENC = SIGNED_OUT ? DPCM_TWOS : DPCM_SIGNMAG;

  logic             r_out_valid;
  logic [WIDTH:0]   r_data;
  logic [CH_W-1:0]  r_chan;

  logic             w_accept;
  logic             w_in_range;
  logic             w_load;
  logic             w_emit;
  logic [WIDTH-1:0] w_pred;
  logic [WIDTH-1:0] w_pred_eff;
  logic [WIDTH:0]   w_enc;

  assign Ready      = ~r_out_valid | OutReady;
  assign w_accept   = Valid & Ready;
  assign w_in_range = (32'(ChanIn) < CHANNELS);
  // Out-of-range channels are consumed from the input but never produce output.
  assign w_load     = w_accept & w_in_range;
  assign w_emit     = r_out_valid & OutReady;

  dpcm_pred_bank #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_pred_bank (
    .clk       (clk),
    .rst       (rst),
    .i_rd_addr (ChanIn),
    .o_rd_data (w_pred),
    .i_wr_en   (w_load),
    .i_wr_addr (ChanIn),
    .i_wr_data (DataIn)
  );

`ifdef DPCM_RESYNC_EN
  logic r_resync;
  assign w_pred_eff = Resync ? '0 : w_pred;
  assign ResyncOut  = r_resync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resync <= 1'b0;
    end else if (w_load) begin
      r_resync <= Resync;
    end
  end
`else
  assign w_pred_eff = w_pred;
`endif

  assign w_enc = (WIDTH+1)'(encode_diff(DPCM_MAX_W'(DataIn), DPCM_MAX_W'(w_pred_eff), ENC, WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_chan      <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_data      <= w_enc;
      r_chan      <= ChanIn;
    end else if (w_emit) begin
      r_out_valid <= 1'b0;
    end
  end

  assign OutValid = r_out_valid;
  assign DataOut  = r_data;
  assign ChanOut  = r_chan;

endmodule
